// File: rtl/dframe_tx_if.sv
// UART-side handshake bundle for the transmit framer.
//   tx_din  : byte handed to the UART transmitter
//   tx_vld  : one-cycle strobe, tx_din valid in the same cycle
//   tx_busy : UART transmitter is shifting a byte (stop bit included)
// master = framer side, slave = UART transmitter side.
interface dframe_tx_if;
  logic [7:0] tx_din;
  logic       tx_vld;
  logic       tx_busy;

  modport master (output tx_din, output tx_vld, input tx_busy);
  modport slave  (input tx_din, input tx_vld, output tx_busy);
endinterface

// File: rtl/dframe_tx.sv
// Transmit-side framer for the Arduino serial link.
// Holds four 40-bit channel words and, on request, sends the selected word
// as a FRA-byte frame (MSB byte first) through the UART transmitter while
// holding the channel address stable until GUARD_CYC cycles after the last
// stop bit.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   ch0..ch3_word     : channel words (temperature, humidity, pressure, force)
//   req[3:0]          : per-channel send request (latched, one cycle or longer)
//   tx                : UART handshake (tx_din / tx_vld out, tx_busy in)
//   add[1:0]          : channel address to the Arduino
//   busy              : frame in progress (LOAD through GUARD)
//   done              : one-cycle pulse when a frame completes
module dframe_tx #(
  parameter int FRA       = 5,
  parameter int GUARD_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [39:0]        ch0_word,
  input  logic [39:0]        ch1_word,
  input  logic [39:0]        ch2_word,
  input  logic [39:0]        ch3_word,
  input  logic [3:0]         req,
  dframe_tx_if.master        tx,
  output logic [1:0]         add,
  output logic               busy,
  output logic               done
);

  localparam int CW = (FRA > 1) ? $clog2(FRA) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO, GUARD} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    pend_reg, pend_next;
  logic [1:0]    last_ch_reg, last_ch_next;
  logic [1:0]    ch_reg, ch_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [15:0]   gcnt_reg, gcnt_next;
  logic [39:0]   snap_reg, snap_next;
  logic [7:0]    tx_din_reg, tx_din_next;
  logic          tx_vld_reg, tx_vld_next;
  logic [1:0]    add_reg, add_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;

  logic [39:0]   words [4];
  logic [1:0]    cand [4];
  logic          sel_found;
  logic [1:0]    sel_ch;
  logic [3:0]    pend_clr;
  logic          last_byte;

  assign words[0] = ch0_word;
  assign words[1] = ch1_word;
  assign words[2] = ch2_word;
  assign words[3] = ch3_word;

  // Round-robin search order: last_ch+1, +2, +3, then last_ch itself (mod 4).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      assign cand[gi] = last_ch_reg + 2'(gi + 1);
    end
  endgenerate

  always_comb begin
    sel_found = 1'b0;
    sel_ch    = last_ch_reg;
    for (int k = 0; k < 4; k++) begin
      if (!sel_found && pend_reg[cand[k]]) begin
        sel_found = 1'b1;
        sel_ch    = cand[k];
      end
    end
  end

  assign last_byte = (cnt_reg == CW'(FRA - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|pend_reg) state_next = LOAD;
      LOAD:    state_next = SEND;
      SEND:    if (!tx.tx_busy) state_next = WAIT_HI;
      WAIT_HI: if (tx.tx_busy) state_next = WAIT_LO;
      WAIT_LO: if (!tx.tx_busy) state_next = last_byte ? GUARD : SEND;
      GUARD:   if (gcnt_reg == 16'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    pend_clr     = 4'b0000;
    last_ch_next = last_ch_reg;
    ch_next      = ch_reg;
    cnt_next     = cnt_reg;
    gcnt_next    = gcnt_reg;
    snap_next    = snap_reg;
    tx_din_next  = tx_din_reg;
    tx_vld_next  = 1'b0;
    add_next     = add_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sel_found) ch_next = sel_ch;
      end
      LOAD: begin
        add_next     = ch_reg;
        last_ch_next = ch_reg;
        snap_next    = words[ch_reg];
        pend_clr     = 4'b0001 << ch_reg;
        cnt_next     = '0;
        busy_next    = 1'b1;
      end
      SEND: begin
        // The snapshot shifts left after each byte, so its top byte is
        // always byte number cnt of the original word.
        if (!tx.tx_busy) begin
          tx_din_next = snap_reg[39:32];
          snap_next   = {snap_reg[31:0], 8'h00};
          tx_vld_next = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!tx.tx_busy) begin
          if (last_byte) gcnt_next = 16'(GUARD_CYC - 1);
          else           cnt_next  = cnt_reg + CW'(1);
        end
      end
      GUARD: begin
        if (gcnt_reg == 16'd0) begin
          done_next = 1'b1;
          busy_next = 1'b0;
        end else begin
          gcnt_next = gcnt_reg - 16'd1;
        end
      end
      default: ;
    endcase
    // A new request in the clearing cycle wins, re-queueing the channel.
    pend_next = (pend_reg & ~pend_clr) | req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg    <= 4'b0000;
      last_ch_reg <= 2'd3;
      ch_reg      <= 2'd0;
      cnt_reg     <= '0;
      gcnt_reg    <= 16'd0;
      snap_reg    <= 40'd0;
      tx_din_reg  <= 8'd0;
      tx_vld_reg  <= 1'b0;
      add_reg     <= 2'd0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      pend_reg    <= pend_next;
      last_ch_reg <= last_ch_next;
      ch_reg      <= ch_next;
      cnt_reg     <= cnt_next;
      gcnt_reg    <= gcnt_next;
      snap_reg    <= snap_next;
      tx_din_reg  <= tx_din_next;
      tx_vld_reg  <= tx_vld_next;
      add_reg     <= add_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  assign tx.tx_din = tx_din_reg;
  assign tx.tx_vld = tx_vld_reg;
  assign add       = add_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule
